// File: rtl/pt_uart_loader.sv
// 8N1 UART receiver and frame assembler feeding 24-bit words to pt_enc through ad/ld.
// Define PT_LOADER_CHECKSUM_EN for 4-byte frames with an XOR trailer byte.
module pt_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned GAP_CLKS     = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        enc_done,
  output logic [23:0] ad,
  output logic        ld,
  output logic        pending,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned GapW    = $clog2(GAP_CLKS + 1);
`ifdef PT_LOADER_CHECKSUM_EN
  localparam logic [2:0]  LastIdx = 3'd3;
`else
  localparam logic [2:0]  LastIdx = 3'd2;
`endif

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

  rx_state_e       state_q, state_d;
  logic            rxd_meta, rxd_sync;
  logic            armed_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            byte_valid, stop_err;

  logic [2:0]      idx_q, idx_d;
  logic [23:0]     shadow_q, shadow_d;
  logic [23:0]     ad_q, ad_d;
  logic            pending_q, pending_d;
  logic            ld_q, ld_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            complete, word_ok;
  logic [23:0]     word;
`ifdef PT_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // A start bit needs the line to have been seen high first, so a held break
  // or a line low at reset release cannot retrigger reception.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
    end else if (stop_err) begin
      armed_q <= 1'b0;
    end else if (rxd_sync) begin
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (armed_q && !rxd_sync) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntW'(HalfBit - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          if (!rxd_sync) begin
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          cnt_d  = '0;
          data_d = {rxd_sync, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntW'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rxd_sync) begin
            byte_valid = 1'b1;
          end else begin
            stop_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      shadow_q  <= '0;
      ad_q      <= '0;
      pending_q <= 1'b0;
      ld_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      gap_q     <= '0;
`ifdef PT_LOADER_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      ad_q      <= ad_d;
      pending_q <= pending_d;
      ld_q      <= ld_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      gap_q     <= gap_d;
`ifdef PT_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  always_comb begin
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    ad_d      = ad_q;
    pending_d = pending_q;
    ld_d      = 1'b0;
    fe_d      = stop_err;
    ov_d      = 1'b0;
    gap_d     = '0;
    complete  = 1'b0;
    word_ok   = 1'b0;
    word      = shadow_q;
`ifdef PT_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    if (pending_q && enc_done) begin
      ld_d      = 1'b1;
      pending_d = 1'b0;
    end

    if (stop_err) begin
      idx_d    = '0;
      shadow_d = '0;
`ifdef PT_LOADER_CHECKSUM_EN
      csum_d   = '0;
`endif
    end else if (byte_valid) begin
      if (idx_q == LastIdx) begin
        idx_d    = '0;
        shadow_d = '0;
        complete = 1'b1;
`ifdef PT_LOADER_CHECKSUM_EN
        word     = shadow_q;
        word_ok  = (data_q == csum_q);
        csum_d   = '0;
`else
        word     = {shadow_q[15:0], data_q};
        word_ok  = 1'b1;
`endif
      end else begin
        idx_d    = idx_q + 3'd1;
        shadow_d = {shadow_q[15:0], data_q};
`ifdef PT_LOADER_CHECKSUM_EN
        csum_d   = csum_q ^ data_q;
`endif
      end
    end else if (state_q == StIdle && idx_q != 3'd0) begin
      // Partial frame stalled on an idle line: drop it silently.
      if (gap_q == GapW'(GAP_CLKS - 1)) begin
        idx_d    = '0;
        shadow_d = '0;
`ifdef PT_LOADER_CHECKSUM_EN
        csum_d   = '0;
`endif
      end else begin
        gap_d = gap_q + GapW'(1);
      end
    end

    // pending_q is the pre-edge value, so a frame finishing on a handoff edge overruns.
    if (complete) begin
      if (!word_ok) begin
        fe_d = 1'b1;
      end else if (pending_q) begin
        ov_d = 1'b1;
      end else begin
        ad_d      = word;
        pending_d = 1'b1;
      end
    end
  end

  assign ad        = ad_q;
  assign ld        = ld_q;
  assign pending   = pending_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_pt_uart_loader.sv
// Directed bench for pt_uart_loader: UART byte stimulus, pulse counters and assertions.
module tb_pt_uart_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        enc_done;
  logic [23:0] ad;
  logic        ld;
  logic        pending;
  logic        frame_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pend_rise = 0;
  logic pend_prev = 1'b0;

  pt_uart_loader #(
    .CLKS_PER_BIT(8),
    .GAP_CLKS    (400)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .enc_done (enc_done),
    .ad       (ad),
    .ld       (ld),
    .pending  (pending),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (ld === 1'b1) ld_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (pending === 1'b1 && !pend_prev) pend_rise++;
      pend_prev <= pending;
    end else begin
      pend_prev <= 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clk(8);
    end
    rxd = stop;
    wait_clk(8);
    rxd = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
`ifdef PT_LOADER_CHECKSUM_EN
    send_byte(b0 ^ b1 ^ b2, 1'b1);
`endif
  endtask

  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    enc_done = 1'b1;
    wait_clk(3);
    chk("rst_ad", 32'(ad), 32'h0);
    chk("rst_ld", 32'(ld), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    wait_clk(4);

    // Encoder idle: word goes straight through with a single ld.
    send_word(8'hAA, 8'hAA, 8'h01);
    wait_clk(4);
    chk("t1_ld_count", 32'(ld_cnt), 32'd1);
    chk("t1_ad", 32'(ad), 32'h00AAAA01);
    chk("t1_pending_rise", 32'(pend_rise), 32'd1);
    chk("t1_pending_clear", 32'(pending), 32'h0);

    // Encoder busy: word waits, ld follows enc_done by one cycle.
    enc_done = 1'b0;
    send_word(8'h12, 8'h34, 8'h56);
    wait_clk(4);
    chk("t2_pending", 32'(pending), 32'h1);
    chk("t2_no_ld", 32'(ld_cnt), 32'd1);
    chk("t2_ad", 32'(ad), 32'h00123456);
    enc_done = 1'b1;
    wait_clk(1);
    chk("t2_ld_high", 32'(ld), 32'h1);
    chk("t2_pending_low", 32'(pending), 32'h0);
    wait_clk(1);
    chk("t2_ld_one_cycle", 32'(ld), 32'h0);

    // Bad stop bit, then a clean frame.
    send_byte(8'h55, 1'b0);
    wait_clk(2);
    chk("t3_frame_err", 32'(fe_cnt), 32'd1);
    send_word(8'h01, 8'h02, 8'h03);
    wait_clk(4);
    chk("t3_ad", 32'(ad), 32'h00010203);
    chk("t3_ld_count", 32'(ld_cnt), 32'd3);

    // Gap timeout drops a partial frame silently.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    wait_clk(450);
    chk("t4_no_ld_gap", 32'(ld_cnt), 32'd3);
    send_word(8'h33, 8'h44, 8'h55);
    wait_clk(4);
    chk("t4_ad", 32'(ad), 32'h00334455);
    chk("t4_ld_count", 32'(ld_cnt), 32'd4);
    chk("t4_no_err", 32'(fe_cnt), 32'd1);

    // Overrun while a word is pending.
    enc_done = 1'b0;
    send_word(8'hA1, 8'hB2, 8'hC3);
    wait_clk(4);
    chk("t5_pending", 32'(pending), 32'h1);
    send_word(8'h01, 8'h02, 8'h03);
    wait_clk(4);
    chk("t5_overrun", 32'(ov_cnt), 32'd1);
    chk("t5_ad_kept", 32'(ad), 32'h00A1B2C3);
    chk("t5_still_pending", 32'(pending), 32'h1);
    enc_done = 1'b1;
    wait_clk(3);
    chk("t5_ld_count", 32'(ld_cnt), 32'd5);

    // Break: one frame_err only, then normal reception.
    rxd = 1'b0;
    wait_clk(200);
    rxd = 1'b1;
    wait_clk(4);
    chk("t6_break_err", 32'(fe_cnt), 32'd2);
    send_word(8'h0A, 8'h0B, 8'h0C);
    wait_clk(4);
    chk("t6_ad", 32'(ad), 32'h000A0B0C);
    chk("t6_ld_count", 32'(ld_cnt), 32'd6);

    // Reset in the middle of a frame.
    send_byte(8'h77, 1'b1);
    rst = 1'b1;
    wait_clk(2);
    chk("t7_rst_ad", 32'(ad), 32'h0);
    chk("t7_rst_pending", 32'(pending), 32'h0);
    rst = 1'b0;
    wait_clk(4);
    send_word(8'h21, 8'h43, 8'h65);
    wait_clk(4);
    chk("t7_ad", 32'(ad), 32'h00214365);
    chk("t7_ld_count", 32'(ld_cnt), 32'd7);
    chk("t7_no_overrun", 32'(ov_cnt), 32'd1);

`ifdef PT_LOADER_CHECKSUM_EN
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_clk(4);
    chk("cs_good_ad", 32'(ad), 32'h00010203);
    chk("cs_good_ld", 32'(ld_cnt), 32'd8);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h07, 1'b1);
    wait_clk(4);
    chk("cs_bad_err", 32'(fe_cnt), 32'd3);
    chk("cs_bad_no_ld", 32'(ld_cnt), 32'd8);
    chk("cs_bad_pending", 32'(pending), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
